// File: rtl/hack_stream_pkg.sv
// Shared types and helpers for the stream demultiplexer slice.
// Optional per-channel beat counters are enabled with DMUX_STREAM_STATS_EN.
package hack_stream_pkg;

    localparam int STATS_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // A 1-channel-wide select would otherwise collapse to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry register slice for a single output channel of dmux_stream.
// With DMUX_STREAM_STATS_EN defined it also keeps a saturating delivery counter.
module dmux_slot
    import hack_stream_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_drain,
`ifdef DMUX_STREAM_STATS_EN
    input  logic               i_cnt_clr,
    output logic [STATS_W-1:0] o_count,
`endif
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    // A load while FULL is only ever issued alongside a drain, so it stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (i_load)            w_state_nxt = FULL;
            FULL:    if (i_drain && !i_load) w_state_nxt = EMPTY;
            default:                        w_state_nxt = EMPTY;
        endcase
    end

    // Data is never cleared on drain; it only changes on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_data <= '0;
        else if (i_load) r_data <= i_data;
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;

`ifdef DMUX_STREAM_STATS_EN
    logic [STATS_W-1:0] r_count;
    logic               w_deliver;

    assign w_deliver = o_valid & i_drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_count <= '0;
        else if (i_cnt_clr)                r_count <= '0;
        else if (w_deliver && ~&r_count)   r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
`endif

endmodule

// File: rtl/dmux_stream.sv
// N-way valid/ready stream demultiplexer with a one-entry slot per channel.
// Define DMUX_STREAM_STATS_EN to add CNT_CLR and per-channel BEAT_COUNT.
module dmux_stream
    import hack_stream_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [WIDTH-1:0]          IN_DATA,
    input  logic [SEL_W-1:0]          IN_SEL,
    output logic [CHANNELS-1:0]       OUT_VALID,
    input  logic [CHANNELS-1:0]       OUT_READY,
    output logic [CHANNELS*WIDTH-1:0] OUT_DATA,
    output logic                      ERR_SEL
`ifdef DMUX_STREAM_STATS_EN
    ,
    input  logic                        CNT_CLR,
    output logic [CHANNELS*STATS_W-1:0] BEAT_COUNT
`endif
);

    localparam logic [SEL_W:0] CH_L = (SEL_W+1)'(CHANNELS);

    logic                w_sel_ok;
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_space;
    logic [CHANNELS-1:0] w_load;
    logic                r_err;

    assign w_sel_ok = ({1'b0, IN_SEL} < CH_L);

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_hit[k] = (IN_SEL == SEL_W'(k));
    end

    // A slot can take a beat if it is empty or being drained this cycle.
    assign w_space  = ~OUT_VALID | OUT_READY;
    assign IN_READY = w_sel_ok ? |(w_hit & w_space) : 1'b1;
    assign w_load   = w_hit & w_space & {CHANNELS{IN_VALID}};

    // Out-of-range beats are swallowed; flag them for one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_err <= 1'b0;
        else        r_err <= IN_VALID & ~w_sel_ok;
    end

    assign ERR_SEL = r_err;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        dmux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (CLK),
            .rst_n     (RST_N),
            .i_load    (w_load[k]),
            .i_data    (IN_DATA),
            .i_drain   (OUT_READY[k]),
`ifdef DMUX_STREAM_STATS_EN
            .i_cnt_clr (CNT_CLR),
            .o_count   (BEAT_COUNT[k*STATS_W +: STATS_W]),
`endif
            .o_valid   (OUT_VALID[k]),
            .o_data    (OUT_DATA[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Parametrised N-way stream demultiplexer with a valid/ready handshake on the input and on every output.
- Each input beat goes to the output channel selected by SEL.
- Each output channel has a one-entry register slot, so backpressure on one channel does not corrupt data on the others.
- Sits between the CPU/memory-map fabric and peripheral sinks (screen, LED, UART); successor to the fixed 8-way 1-bit combinational demux.

Parameters:
- WIDTH, 16, data width per beat in bits (≥1).
- CHANNELS, 8, number of output channels (2..64; need not be a power of two).
- SEL_W, $clog2(CHANNELS), select width; derived, not overridden.

Ports:
- CLK  input  1  single clock; all state changes on rising edge.
- RST_N  input  1  asynchronous, active-low reset; deassertion synchronous to CLK externally.
- IN_VALID  input  1  input beat present.
- IN_READY  output  1  block accepts the beat this cycle.
- IN_DATA  input  WIDTH  beat payload.
- IN_SEL  input  SEL_W  destination channel, sampled with the beat.
- OUT_VALID  output  CHANNELS  per-channel slot full.
- OUT_READY  input  CHANNELS  per-channel sink accepts.
- OUT_DATA  output  CHANNELS*WIDTH  flattened; channel k occupies bits [k*WIDTH +: WIDTH].
- ERR_SEL  output  1  one-cycle pulse: a beat with IN_SEL ≥ CHANNELS was accepted and dropped.

Behaviour:
- Reset (RST_N=0, immediate, no clock needed): all OUT_VALID=0, all OUT_DATA=0, ERR_SEL=0. Mid-operation reset discards all held beats; no partial delivery.
- Per-channel slot states: EMPTY, FULL.
  - EMPTY → FULL on load.
  - FULL → EMPTY on OUT_READY[k] with no simultaneous load.
  - FULL → FULL on simultaneous drain and load; the new data replaces the old in the same cycle.
- Readiness:
  - IN_READY = ~OUT_VALID[IN_SEL] | OUT_READY[IN_SEL] when IN_SEL < CHANNELS.
  - IN_READY = 1 when IN_SEL ≥ CHANNELS.
  - IN_READY is combinational from IN_SEL/OUT_VALID/OUT_READY and never depends on IN_VALID.
- Transfer: a beat transfers when IN_VALID & IN_READY. Latency 1 cycle: the beat appears on OUT_DATA[k] with OUT_VALID[k]=1 at the next edge.
- Throughput: one beat per cycle sustained to a single channel whose sink holds OUT_READY=1.
- Output stability: OUT_DATA[k] is held stable while OUT_VALID[k]=1 and OUT_READY[k]=0. It retains the last value after draining; it is not cleared.
- Channel independence: channels are independent. Only the selected channel's slot changes on a transfer; the others drain concurrently.
- Invalid select: a beat with IN_SEL ≥ CHANNELS is consumed (IN_READY=1), no slot changes, and ERR_SEL=1 for exactly the following cycle.
- Input rules: IN_SEL and IN_DATA are don't-care when IN_VALID=0. The upstream producer must hold the beat stable until the transfer; the block does not check this.

Optional Feature:
- Macro: DMUX_STREAM_STATS_EN.
- When defined:
  - Adds output port BEAT_COUNT (CHANNELS*16): per-channel count of beats delivered (OUT_VALID & OUT_READY).
  - Each counter is 16-bit, saturates at 0xFFFF, and resets to 0.
  - Adds input CNT_CLR (1): synchronous clear of all counters. Clear wins over an increment in the same cycle.
- When undefined: neither port exists, and no counter logic is present.

Decomposition:
- Package hack_stream_pkg:
  - function clog2_min1, returning at least 1 so that SEL_W ≥ 1.
  - localparam STATS_W=16.
  - enum slot_state_t {EMPTY, FULL}.
- Sub-module dmux_slot: one-entry register slice (WIDTH-parametrised; load, drain, valid, data, optional counter), instantiated CHANNELS times via generate.
- The top level holds select decode, IN_READY mux, and ERR_SEL.

Test Plan:
- Reset state: RST_N low for 3 cycles, then released → OUT_VALID=0, OUT_DATA all 0, ERR_SEL=0. IN_READY=1 for any IN_SEL.
- Basic routing (WIDTH=16, CHANNELS=8): send 0xA5A5 with IN_SEL=5, all OUT_READY=1 → next cycle OUT_VALID=0b0010_0000, OUT_DATA[5]=0xA5A5; one cycle later OUT_VALID=0.
- Backpressure: hold OUT_READY[2]=0 and send two beats to channel 2 (0x0001, 0x0002) → first held with OUT_VALID[2]=1, IN_READY=0 on the second. Meanwhile a beat 0x0003 to channel 3 is accepted. Raise OUT_READY[2] → 0x0001 drains, 0x0002 loads in the same cycle.
- Invalid select (CHANNELS=6): IN_SEL=7, IN_DATA=0xFFFF → accepted, ERR_SEL pulses 1 cycle, OUT_VALID unchanged.
- Async reset mid-burst: drop RST_N between edges while channels 0 and 4 are FULL → OUT_VALID=0 immediately, before the next edge.
- Stats (DMUX_STREAM_STATS_EN): deliver 70000 beats to channel 1 → BEAT_COUNT[1]=0xFFFF. Pulse CNT_CLR coincident with a delivery → 0.
